// File: rtl/alu_op_sequencer_if.sv
// Operand/opcode/result bus between the sequencer and the ALU datapath.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 6,
  parameter int OPW   = 4
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_y, alu_c
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_y, alu_c
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Loads A, B and opcode from a shared switch bus, lets the ALU settle for
// EXEC_CYCLES clocks, then captures the result with zero/carry flags.
module alu_op_sequencer #(
  parameter int WIDTH       = 6,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              load,
  input  logic              clear,
  alu_op_sequencer_if.master alu,
  output logic [WIDTH-1:0]  result,
  output logic              flag_z,
  output logic              flag_c,
  output logic [2:0]        state_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load_q;
  logic             load_ev;
  logic [WIDTH-1:0] a_q, a_nx;
  logic [WIDTH-1:0] b_q, b_nx;
  logic [OPW-1:0]   op_q, op_nx;
  logic [WIDTH-1:0] res_q, res_nx;
  logic             z_q, z_nx;
  logic             c_q, c_nx;
  logic             done_q, done_nx;

  // load_q resets high so a level held through reset is not seen as an edge
  assign load_ev = load & ~load_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_A;
      cnt    <= '0;
      load_q <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      load_q <= load;
      a_q    <= a_nx;
      b_q    <= b_nx;
      op_q   <= op_nx;
      res_q  <= res_nx;
      z_q    <= z_nx;
      c_q    <= c_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_nx     = a_q;
    b_nx     = b_q;
    op_nx    = op_q;
    res_nx   = res_q;
    z_nx     = z_q;
    c_nx     = c_q;
    done_nx  = 1'b0;
    if (clear) begin
      // Soft clear keeps the last displayed result and flags
      state_nx = S_A;
      cnt_nx   = '0;
      a_nx     = '0;
      b_nx     = '0;
      op_nx    = '0;
    end else begin
      case (state)
        S_A: begin
          if (load_ev) begin
            a_nx     = data_in;
            state_nx = S_B;
          end
        end
        S_B: begin
          if (load_ev) begin
            b_nx     = data_in;
            state_nx = S_OP;
          end
        end
        S_OP: begin
          if (load_ev) begin
            op_nx    = data_in[OPW-1:0];
            cnt_nx   = CNT_W'(EXEC_CYCLES - 1);
            state_nx = S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != '0) begin
            cnt_nx = cnt - CNT_W'(1);
          end else begin
            res_nx   = alu.alu_y;
            c_nx     = alu.alu_c;
            z_nx     = (alu.alu_y == '0);
            done_nx  = 1'b1;
            state_nx = S_SHOW;
          end
        end
        S_SHOW: begin
          if (load_ev) begin
            a_nx     = data_in;
            state_nx = S_B;
          end
        end
        default: state_nx = S_A;
      endcase
    end
  end

  assign alu.alu_a  = a_q;
  assign alu.alu_b  = b_q;
  assign alu.alu_op = op_q;
  assign result     = res_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign done       = done_q;
  assign state_out  = state;
  assign busy       = (state == S_EXEC);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (EXEC_CYCLES 2 and 1) against a latency-based model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, load, clear;
  logic [5:0] data_in;

  logic [5:0] result    [2];
  logic       flag_z    [2];
  logic       flag_c    [2];
  logic       busy      [2];
  logic       done      [2];
  logic [2:0] state_out [2];
  logic [28:0] act      [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] alu_f(logic [5:0] a, logic [5:0] b, logic [3:0] op);
    logic [6:0] r;
    case (op)
      4'h0:    r = {1'b0, a} + {1'b0, b};
      4'h1:    r = {1'b0, a} - {1'b0, b};
      4'h2:    r = {1'b0, a & b};
      4'h3:    r = {1'b0, a ^ b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  alu_op_sequencer_if #(.WIDTH(6), .OPW(4)) bus0 ();
  alu_op_sequencer_if #(.WIDTH(6), .OPW(4)) bus1 ();

  assign {bus0.alu_c, bus0.alu_y} = alu_f(bus0.alu_a, bus0.alu_b, bus0.alu_op);
  assign {bus1.alu_c, bus1.alu_y} = alu_f(bus1.alu_a, bus1.alu_b, bus1.alu_op);

  alu_op_sequencer #(.WIDTH(6), .OPW(4), .EXEC_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clear(clear),
    .alu(bus0), .result(result[0]), .flag_z(flag_z[0]), .flag_c(flag_c[0]),
    .state_out(state_out[0]), .busy(busy[0]), .done(done[0])
  );

  alu_op_sequencer #(.WIDTH(6), .OPW(4), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clear(clear),
    .alu(bus1), .result(result[1]), .flag_z(flag_z[1]), .flag_c(flag_c[1]),
    .state_out(state_out[1]), .busy(busy[1]), .done(done[1])
  );

  assign act[0] = {bus0.alu_a, bus0.alu_b, bus0.alu_op, result[0], flag_z[0], flag_c[0],
                   state_out[0], busy[0], done[0]};
  assign act[1] = {bus1.alu_a, bus1.alu_b, bus1.alu_op, result[1], flag_z[1], flag_c[1],
                   state_out[1], busy[1], done[1]};

  // Model: operation = three accepted loads; result appears N edges after the opcode load.
  logic [5:0] m_a [2], m_b [2], m_res [2];
  logic [3:0] m_op [2];
  logic       m_z [2], m_c [2], m_done [2], m_lq [2];
  int         m_nl [2], m_edges [2];
  bit         m_exec [2], m_show [2];

  always @(posedge clk) begin
    bit         ev;
    int         n;
    logic [2:0] st;
    logic [28:0] exp;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 2 : 1;
      if (rst) begin
        m_a[k] = '0; m_b[k] = '0; m_op[k] = '0; m_res[k] = '0;
        m_z[k] = 1'b0; m_c[k] = 1'b0; m_done[k] = 1'b0; m_lq[k] = 1'b1;
        m_nl[k] = 0; m_edges[k] = 0; m_exec[k] = 1'b0; m_show[k] = 1'b0;
      end else begin
        ev       = load && !m_lq[k];
        m_lq[k]  = load;
        m_done[k] = 1'b0;
        if (clear) begin
          m_a[k] = '0; m_b[k] = '0; m_op[k] = '0;
          m_nl[k] = 0; m_exec[k] = 1'b0; m_show[k] = 1'b0;
        end else if (m_exec[k]) begin
          m_edges[k]++;
          if (m_edges[k] == n) begin
            {m_c[k], m_res[k]} = alu_f(m_a[k], m_b[k], m_op[k]);
            m_z[k]    = (m_res[k] == 6'd0);
            m_done[k] = 1'b1;
            m_exec[k] = 1'b0;
            m_show[k] = 1'b1;
          end
        end else if (ev) begin
          if (m_nl[k] == 0) begin
            m_a[k] = data_in; m_nl[k] = 1; m_show[k] = 1'b0;
          end else if (m_nl[k] == 1) begin
            m_b[k] = data_in; m_nl[k] = 2;
          end else begin
            m_op[k] = data_in[3:0]; m_nl[k] = 0; m_exec[k] = 1'b1; m_edges[k] = 0;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      st  = m_exec[k] ? 3'd3 : (m_show[k] ? 3'd4 : 3'(m_nl[k]));
      exp = {m_a[k], m_b[k], m_op[k], m_res[k], m_z[k], m_c[k], st, m_exec[k], m_done[k]};
      vectors++;
      if (act[k] !== exp) begin
        miscompares++;
        $display("FAIL cycle_dut%0d @%0t: got a=%h b=%h op=%h res=%h z=%b c=%b st=%0d busy=%b done=%b, expected a=%h b=%h op=%h res=%h z=%b c=%b st=%0d busy=%b done=%b",
                 k, $time, act[k][28:23], act[k][22:17], act[k][16:13], act[k][12:7], act[k][6],
                 act[k][5], act[k][4:2], act[k][1], act[k][0], exp[28:23], exp[22:17],
                 exp[16:13], exp[12:7], exp[6], exp[5], exp[4:2], exp[1], exp[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [5:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic xor_run();
    pulse_clear();
    do_load(6'h2A);
    do_load(6'h15);
    do_load(6'h03);
    cyc(2);
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; clear = 1'b0; data_in = '0;
    cyc(3);
    chk("rst_state", state_out[0], 3'd0);
    chk("rst_result", result[0], 6'h00);
    chk("rst_outs", {busy[0], done[0], flag_z[0], flag_c[0]}, 4'h0);
    rst = 1'b0;
    cyc(3);
    chk("held_through_rst", state_out[0], 3'd0);
    load = 1'b0;
    cyc(1);

    // XOR run from idle
    do_load(6'h2A);
    chk("a_loaded", bus0.alu_a, 6'h2A);
    do_load(6'h15);
    data_in = 6'h03; load = 1'b1;
    @(negedge clk);
    chk("busy_t0", busy[0], 1'b1);
    load = 1'b0;
    @(negedge clk);
    chk("busy_t1", {busy[0], done[0]}, 2'b10);
    chk("n1_done_t1", {done[1], result[1]}, {1'b1, 6'h3F});
    @(negedge clk);
    chk("xor_result", result[0], 6'h3F);
    chk("xor_flags", {flag_z[0], flag_c[0], done[0]}, 3'b001);
    chk("xor_state", state_out[0], 3'd4);
    chk("model_res", m_res[0], 6'h3F);
    @(negedge clk);
    chk("done_one_cycle", done[0], 1'b0);

    // Zero flag, starting straight from S_SHOW
    do_load(6'h2A);
    do_load(6'h2A);
    do_load(6'h03);
    cyc(2);
    chk("zero_result", {flag_z[0], result[0]}, {1'b1, 6'h00});

    // Held load captures once; loads during execution are dropped
    pulse_clear();
    data_in = 6'h11; load = 1'b1;
    cyc(10);
    load = 1'b0;
    cyc(1);
    chk("held_a", {state_out[0], bus0.alu_a}, {3'd1, 6'h11});
    do_load(6'h22);
    data_in = 6'h00; load = 1'b1;
    @(negedge clk);
    load = 1'b0; data_in = 6'h3F;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("exec_ignore_ops", {bus0.alu_a, bus0.alu_b, bus0.alu_op}, {6'h11, 6'h22, 4'h0});
    chk("add_result", {state_out[0], result[0]}, {3'd4, 6'h33});

    // Clear aborts execution
    xor_run();
    do_load(6'h05);
    do_load(6'h07);
    data_in = 6'h03; load = 1'b1;
    @(negedge clk);
    load = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_state", state_out[0], 3'd0);
    chk("clr_ops", {bus0.alu_a, bus0.alu_b, bus0.alu_op}, 16'h0);
    chk("clr_keep_res", {done[0], result[0]}, {1'b0, 6'h3F});
    chk("clr_n1", {done[1], state_out[1], result[1]}, {1'b0, 3'd0, 6'h3F});
    cyc(3);

    // Back-to-back start, then reset mid-operation
    xor_run();
    do_load(6'h01);
    chk("b2b_a", {state_out[0], bus0.alu_a, result[0]}, {3'd1, 6'h01, 6'h3F});
    do_load(6'h02);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_midop", act[0], 29'h0);
    rst = 1'b0;
    cyc(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) load = ~load;
      data_in = 6'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; clear = 1'b0; load = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequencing controller for the 6-bit ALU datapath (XOR and sibling operation units behind the opcode mux). It captures operand A, operand B and the opcode from a shared switch bus on successive load strobes. It drives the ALU inputs, waits a fixed settle time, then registers the result with zero and carry flags for display. It sits between the debounced board inputs and the ALU top.

Parameters:
WIDTH, 6, operand/result width in bits
OPW, 4, opcode width in bits (must be <= WIDTH)
EXEC_CYCLES, 2, clocks from start of execution to result capture (>= 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
data_in  in  WIDTH  shared switch bus: operand A, operand B, then opcode in bits [OPW-1:0]
load  in  1  debounced level; each rising edge is one load event
clear  in  1  synchronous soft clear, active-high
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_op  out  OPW  registered opcode to ALU
alu_y  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
alu_c  in  1  ALU carry/borrow flag
result  out  WIDTH  captured result
flag_z  out  1  captured result == 0
flag_c  out  1  captured alu_c
state_out  out  3  current state code, for LEDs
busy  out  1  high while in S_EXEC
done  out  1  one-cycle pulse after result capture

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: alu_a, alu_b, alu_op, result = 0; flag_z, flag_c, done, busy = 0; state = S_A; internal cnt = 0; load_q = 1.
- load_q = 1 at reset suppresses a spurious event if load is held high through reset.
- Edge detect: load_q <= load every clock. A load event is load & ~load_q. A held level produces exactly one event.
- Priority: rst > clear > load event.
- States, encoded on state_out: S_A = 0, S_B = 1, S_OP = 2, S_EXEC = 3, S_SHOW = 4. Codes 5-7 are unreachable and recover to S_A next clock.
- S_A: on event, alu_a <= data_in, go to S_B.
- S_B: on event, alu_b <= data_in, go to S_OP.
- S_OP: on event, alu_op <= data_in[OPW-1:0], cnt <= EXEC_CYCLES-1, go to S_EXEC.
- S_EXEC:
  - Load events are ignored (dropped, not queued).
  - If cnt != 0, cnt decrements.
  - If cnt == 0: result <= alu_y, flag_c <= alu_c, flag_z <= (alu_y == 0), done <= 1, go to S_SHOW.
- S_SHOW:
  - result and flags hold.
  - On event, alu_a <= data_in and go to S_B, so a new operation starts directly. result and flags keep their old values until the next capture.
- Latency: let t0 be the clock edge that samples the opcode event.
  - Capture occurs at edge t0 + EXEC_CYCLES.
  - done is high exactly for the cycle following that edge, coincident with the new result being visible.
- done is 0 in all other cycles. busy is decoded from state == S_EXEC.
- clear, from any state:
  - state <= S_A.
  - alu_a, alu_b, alu_op, cnt <= 0; done <= 0.
  - result, flag_z and flag_c are retained.
  - clear in S_EXEC aborts the capture; done is not pulsed.
- rst mid-operation returns every register to its reset value on that edge.
- Widths: the upper WIDTH-OPW bits of data_in are ignored in S_OP. The block performs no arithmetic other than the zero compare and the cnt decrement.

Test Plan:
1. Reset: assert rst 3 cycles with load = 1 -> all outputs 0, state_out = 0. Release rst with load still high -> no capture; state stays 0 until load falls and rises again.
2. XOR run (bench ALU model: op 4'h3 = XOR, carry 0):
   - Stimulus: load events with data_in = 6'h2A, 6'h15, 6'h03.
   - Required: busy = 1 for 2 cycles, then result = 6'h3F, flag_z = 0, flag_c = 0, done high for exactly one cycle at t0+2, state_out = 4.
3. Zero flag: A = 6'h2A, B = 6'h2A, op 4'h3 -> result = 6'h00, flag_z = 1.
4. Held and ignored loads:
   - load held high 10 cycles in S_A -> alu_a captured once, state_out = 1.
   - Load events during S_EXEC -> no change to alu_a/alu_b/alu_op, capture proceeds normally.
5. Clear during S_EXEC:
   - Stimulus: after a prior result 6'h3F, start a new operation and assert clear during S_EXEC.
   - Required: state_out = 0; alu_a/alu_b/alu_op = 0; done never pulses; result stays 6'h3F.
6. Back-to-back and reset mid-op:
   - From S_SHOW, load event with data_in = 6'h01 -> alu_a = 1, state_out = 1, result unchanged.
   - Then rst in S_OP -> all outputs 0 on the next edge.
   - Repeat test 2 with EXEC_CYCLES = 1 -> done at t0+1.
